// File: rtl/control_sequencer.sv
// control_sequencer: hard-wired fetch/execute control unit.
// Steps RST -> T0..T7 -> T0 per instruction and Moore-decodes the
// state plus ir[31:27] into register-select and datapath strobes.
// Optional build macro: CTRL_ILLEGAL_TRAP_EN (undefined opcode traps to HALT
// and sets the sticky illegal flag; otherwise it executes as nop).
module control_sequencer #(
    parameter logic [4:0] ADD_OP = 5'b00011
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [31:0] ir,
    input  logic        con_ff,
    output logic        gra,
    output logic        grb,
    output logic        grc,
    output logic        rin,
    output logic        rout,
    output logic        baout,
    output logic        pc_out,
    output logic        pc_in,
    output logic        inc_pc,
    output logic        mar_in,
    output logic        mdr_in,
    output logic        mdr_out,
    output logic        ir_in,
    output logic        y_in,
    output logic        z_in,
    output logic        zlow_out,
    output logic        c_out,
    output logic        con_in,
    output logic        mem_read,
    output logic        mem_write,
    output logic [4:0]  alu_op,
    output logic        run,
    output logic        illegal
);

    localparam logic [4:0] OP_LD   = 5'b00000;
    localparam logic [4:0] OP_LDI  = 5'b00001;
    localparam logic [4:0] OP_ST   = 5'b00010;
    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_OR   = 5'b00110;
    localparam logic [4:0] OP_ADDI = 5'b01100;
    localparam logic [4:0] OP_BR   = 5'b10010;
    localparam logic [4:0] OP_JR   = 5'b10100;
    localparam logic [4:0] OP_NOP  = 5'b11010;
    localparam logic [4:0] OP_HALT = 5'b11011;

    typedef enum logic [3:0] {
        S_RST, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    state_t     state, state_next;
    logic [4:0] opcode;
    logic       is_rtype, is_imm, is_ld, is_st, is_br, is_jr, is_nop, is_halt;
    logic       is_defined;
    logic       unused_ir_fields;

    assign opcode           = ir[31:27];
    assign unused_ir_fields = ^ir[26:0];

    assign is_rtype   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                        (opcode == OP_AND) || (opcode == OP_OR);
    assign is_imm     = (opcode == OP_ADDI) || (opcode == OP_LDI);
    assign is_ld      = (opcode == OP_LD);
    assign is_st      = (opcode == OP_ST);
    assign is_br      = (opcode == OP_BR);
    assign is_jr      = (opcode == OP_JR);
    assign is_nop     = (opcode == OP_NOP);
    assign is_halt    = (opcode == OP_HALT);
    assign is_defined = is_rtype | is_imm | is_ld | is_st | is_br |
                        is_jr | is_nop | is_halt;

    // State register; reset forces RST from any state.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= S_RST;
        else          state <= state_next;
    end

    // Next-state sequencing by opcode class.
    always_comb begin
        state_next = state;
        case (state)
            S_RST: state_next = S_T0;
            S_T0:  state_next = S_T1;
            S_T1:  state_next = S_T2;
            S_T2:  state_next = S_T3;
            S_T3: begin
                if (is_halt)
                    state_next = S_HALT;
                else if (is_rtype || is_imm || is_ld || is_st || is_br)
                    state_next = S_T4;
                else if (is_jr || is_nop)
                    state_next = S_T0;
                else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    state_next = S_HALT;
`else
                    state_next = S_T0;
`endif
                end
            end
            S_T4:  state_next = S_T5;
            S_T5:  state_next = (is_ld || is_st || is_br) ? S_T6 : S_T0;
            S_T6:  state_next = is_br ? S_T0 : S_T7;
            S_T7:  state_next = S_T0;
            S_HALT: state_next = S_HALT;
            default: state_next = S_RST;
        endcase
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    logic illegal_q;

    // Sticky flag: set when an undefined opcode reaches T3, cleared by reset.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)                          illegal_q <= 1'b0;
        else if (state == S_T3 && !is_defined) illegal_q <= 1'b1;
    end

    assign illegal = illegal_q;
`else
    logic unused_defined;
    assign unused_defined = is_defined;
    assign illegal        = 1'b0;
`endif

    assign run = (state != S_HALT);

    // Moore strobe decode of state and held opcode.
    always_comb begin
        gra = 1'b0; grb = 1'b0; grc = 1'b0;
        rin = 1'b0; rout = 1'b0; baout = 1'b0;
        pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0;
        mar_in = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
        y_in = 1'b0; z_in = 1'b0; zlow_out = 1'b0; c_out = 1'b0;
        con_in = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
        alu_op = '0;
        case (state)
            S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; z_in = 1'b1; end
            S_T1: begin zlow_out = 1'b1; pc_in = 1'b1; mem_read = 1'b1; mdr_in = 1'b1; end
            S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
            S_T3: begin
                if (is_rtype) begin
                    grb = 1'b1; rout = 1'b1; y_in = 1'b1;
                end else if (is_imm || is_ld || is_st) begin
                    grb = 1'b1; baout = 1'b1; y_in = 1'b1;
                end else if (is_br) begin
                    gra = 1'b1; rout = 1'b1; con_in = 1'b1;
                end else if (is_jr) begin
                    gra = 1'b1; rout = 1'b1; pc_in = 1'b1;
                end
            end
            S_T4: begin
                if (is_rtype) begin
                    grc = 1'b1; rout = 1'b1; z_in = 1'b1; alu_op = opcode;
                end else if (is_imm || is_ld || is_st) begin
                    c_out = 1'b1; z_in = 1'b1; alu_op = ADD_OP;
                end else if (is_br) begin
                    pc_out = 1'b1; y_in = 1'b1;
                end
            end
            S_T5: begin
                if (is_rtype || is_imm) begin
                    zlow_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (is_ld || is_st) begin
                    zlow_out = 1'b1; mar_in = 1'b1;
                end else if (is_br) begin
                    c_out = 1'b1; z_in = 1'b1; alu_op = ADD_OP;
                end
            end
            S_T6: begin
                if (is_ld) begin
                    mem_read = 1'b1; mdr_in = 1'b1;
                end else if (is_st) begin
                    gra = 1'b1; rout = 1'b1; mdr_in = 1'b1;
                end else if (is_br && con_ff) begin
                    zlow_out = 1'b1; pc_in = 1'b1;
                end
            end
            S_T7: begin
                if (is_ld) begin
                    mdr_out = 1'b1; gra = 1'b1; rin = 1'b1;
                end else if (is_st) begin
                    mem_write = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hard-wired control unit for the datapath. It steps an instruction through fetch and execute states and drives the register select/encode stage: Gra/Grb/Grc select the IR register field, and Rin/Rout/BAout qualify the one-hot register enables. It also drives the PC, MAR, MDR, Y, Z, IR and CON strobes and the ALU operation. It sits between the IR and the select/encode logic; the only instruction information it uses is `ir[31:27]`.

## Interface
Parameters:
- ADD_OP, 5'b00011, ALU code used for address and branch-target computation.

Ports:
- clock  in  1  system clock; every state change happens on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ir  in  32  IR register contents; opcode is `ir[31:27]`.
- con_ff  in  1  registered branch condition from the CON logic.
- gra, grb, grc  out  1 each  field selects for select/encode.
- rin, rout, baout  out  1 each  register-file in/out qualifiers.
- pc_out, pc_in, inc_pc, mar_in, mdr_in, mdr_out, ir_in, y_in, z_in, zlow_out, c_out, con_in  out  1 each  datapath strobes.
- mem_read, mem_write  out  1 each  memory strobes.
- alu_op  out  5  ALU operation code.
- run  out  1  1 while executing, 0 when halted.
- illegal  out  1  sticky illegal-opcode flag (see Configuration).

## Operation
- States: RST, T0–T7, HALT.
  - Outputs are a Moore decode of the state register and the held `ir`.
  - `ir` changes only at the end of T2, so decode in T3–T7 sees the fetched instruction.
- Fetch, common to all instructions:
  - T0: pc_out, mar_in, inc_pc, z_in.
  - T1: zlow_out, pc_in, mem_read, mdr_in.
  - T2: mdr_out, ir_in.
- R-type (add 00011, sub 00100, and 00101, or 00110):
  - T3: grb, rout, y_in.
  - T4: grc, rout, z_in, alu_op = opcode.
  - T5: zlow_out, gra, rin.
  - Then → T0.
- addi 01100, ldi 00001:
  - T3: grb, baout, y_in.
  - T4: c_out, z_in, alu_op = ADD_OP.
  - T5: zlow_out, gra, rin.
  - Then → T0.
- ld 00000:
  - T3/T4 as ldi.
  - T5: zlow_out, mar_in.
  - T6: mem_read, mdr_in.
  - T7: mdr_out, gra, rin.
  - Then → T0.
- st 00010:
  - T3/T4 as ldi.
  - T5: zlow_out, mar_in.
  - T6: gra, rout, mdr_in.
  - T7: mem_write.
  - Then → T0.
- br 10010:
  - T3: gra, rout, con_in.
  - T4: pc_out, y_in.
  - T5: c_out, z_in, alu_op = ADD_OP.
  - T6: if con_ff = 1, zlow_out and pc_in; otherwise no strobes.
  - Then → T0.
- jr 10100:
  - T3: gra, rout, pc_in.
  - Then → T0.
- nop 11010: T3 has no strobes, then → T0.
- halt 11011: T3 → HALT. HALT holds with all strobes 0 and run = 0 until reset.
- At most one of gra/grb/grc is asserted in any state. rout and baout are never asserted together.
- Any output not listed for a state is 0. alu_op is 0 when unused.

## Timing
- Reset:
  - reset_n low immediately forces state RST, from any state.
  - In RST: all outputs 0, run = 1, illegal = 0.
  - The first rising edge with reset_n high moves RST → T0.
- Each state lasts exactly one cycle; there are no wait states. Memory reads return within the asserting cycle.
- Cycles per instruction, from T0 back to T0:
  - R-type, addi, ldi: 6.
  - ld, st: 8.
  - br: 7.
  - jr, nop: 4.
- br samples con_ff in T6. con_ff is loaded by con_in at the end of T3, so it is stable by T6.
- Outputs follow state changes combinationally after the clock edge. Consumers register them on the next edge.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined:
  - An undefined opcode in T3 sets illegal = 1 and moves → HALT.
  - illegal stays 1 until reset.
- Not defined:
  - An undefined opcode executes as nop (T3 → T0, no strobes).
  - illegal is tied to 0.

## Test plan
- Reset mid-instruction: drop reset_n during T4 of an add → all outputs 0 immediately; after release, RST, then T0 with pc_out = mar_in = inc_pc = z_in = 1 on the next cycle.
- add R1,R2,R3 (ir = 0x18918000) → over 6 cycles: T3 grb+rout+y_in, T4 grc+rout+z_in with alu_op = 00011, T5 gra+rin+zlow_out; then T0.
- ld R4,0x10(R2) (ir = 0x02100010) → T3 grb+baout+y_in, T4 alu_op = 00011, T7 mdr_out+gra+rin; 8 cycles total.
- br with con_ff = 1, then the same br with con_ff = 0 → T6 asserts zlow_out+pc_in in the first run only; T6 has no strobes in the second; both take 7 cycles.
- halt (ir = 0xD8000000) → run = 0 from the cycle after T3 and stays 0 for 20+ cycles; a reset pulse restarts fetch.
- Opcode 11111: with CTRL_ILLEGAL_TRAP_EN → illegal = 1 and run = 0; without it → back in T0 after 4 cycles with illegal = 0.
